// File: rtl/lt_sched_pkg.sv
// Shared types and constants for the latency-engine scheduler.
package lt_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_ARMED,
        ST_RUN,
        ST_FINISH
    } state_t;

    // Engine ID is stamped into each parameter half at this field.
    localparam int ENG_ID_OFS = 225;
    localparam int ENG_ID_W   = 5;

    localparam int HOLD_LEN   = 2;
    localparam int FINISH_LEN = 1;
    localparam int PHASE_W    = 2;

endpackage

// File: rtl/lt_sched_done_track.sv
// Sticky per-engine completion masks and the all-armed-engines-finished compare.
module lt_sched_done_track #(
    parameter int NUM_ENGINES = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   en,
    input  logic [NUM_ENGINES-1:0] end_wr,
    input  logic [NUM_ENGINES-1:0] end_rd,
    input  logic [NUM_ENGINES-1:0] arm_wr,
    input  logic [NUM_ENGINES-1:0] arm_rd,
    output logic                   all_done
);

    logic [NUM_ENGINES-1:0] seen_wr, seen_rd;
    logic [NUM_ENGINES-1:0] seen_wr_nxt, seen_rd_nxt;

    assign seen_wr_nxt = seen_wr | end_wr;
    assign seen_rd_nxt = seen_rd | end_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_wr <= '0;
            seen_rd <= '0;
        end else if (clear) begin
            seen_wr <= '0;
            seen_rd <= '0;
        end else if (en) begin
            seen_wr <= seen_wr_nxt;
            seen_rd <= seen_rd_nxt;
        end
    end

    // Includes this cycle's ends so the run closes on the cycle of the last end.
    assign all_done = ((seen_wr_nxt & arm_wr) == arm_wr) &&
                      ((seen_rd_nxt & arm_rd) == arm_rd);

endmodule

// File: rtl/lt_sched.sv
// Latency-engine scheduler: loads per-engine parameters, launches armed engines, times the run.
// Optional run watchdog enabled by defining LT_SCHED_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no engines armed, accepting commands
// LOAD      | one-cycle ld pulse to engines, arm bit set
// HOLD      | parameter bus settling (HOLD_LEN cycles)
// ARMED     | at least one engine armed, accepting commands or go
// RUN       | engines running, collecting end flags
// FINISH    | done pulse, arm masks cleared
module lt_sched
    import lt_sched_pkg::*;
#(
    parameter int          NUM_ENGINES    = 32,
    parameter int          PARAMS_BITS    = 256,
    parameter logic [63:0] TIMEOUT_CYCLES = 64'hFFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [4:0]               cmd_engine,
    input  logic                     cmd_dir,
    input  logic [PARAMS_BITS-1:0]   cmd_params,
    input  logic                     go,
    input  logic                     abort,
    output logic                     ld_params_wr,
    output logic                     ld_params_rd,
    output logic [2*PARAMS_BITS-1:0] lt_params,
    output logic [NUM_ENGINES-1:0]   start_wr,
    output logic [NUM_ENGINES-1:0]   start_rd,
    input  logic [NUM_ENGINES-1:0]   end_wr,
    input  logic [NUM_ENGINES-1:0]   end_rd,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic                     timed_out,
    output logic [63:0]              run_cycles
);

    state_t                 state, state_nxt;
    logic [PHASE_W-1:0]     phase_cnt;
    logic                   ld_dir;
    logic [4:0]             ld_eng;
    logic [NUM_ENGINES-1:0] arm_wr, arm_rd, eng_bit;
    logic [PARAMS_BITS-1:0] ld_word;
    logic [63:0]            run_cycles_inc;
    logic                   accept, eng_ok, launch, all_done;

    // Outputs must read 0 while reset is held, so ready is gated by rst too.
    assign cmd_ready      = !rst && ((state == ST_IDLE) || (state == ST_ARMED));
    assign accept         = cmd_valid && cmd_ready;
    assign eng_ok         = ({1'b0, cmd_engine} < 6'(NUM_ENGINES));
    assign launch         = (state == ST_ARMED) && go && ((|arm_wr) || (|arm_rd)) &&
                            !(accept && eng_ok);
    assign eng_bit        = NUM_ENGINES'(1) << ld_eng;
    assign run_cycles_inc = (&run_cycles) ? run_cycles : run_cycles + 64'd1;

    always_comb begin
        ld_word = cmd_params;
        ld_word[ENG_ID_OFS +: ENG_ID_W] = cmd_engine;
    end

`ifdef LT_SCHED_TIMEOUT_EN
    logic to_hit;
    assign to_hit = (run_cycles_inc == TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timed_out <= 1'b0;
        else if (launch)
            timed_out <= 1'b0;
        else if ((state == ST_RUN) && !abort && !all_done && to_hit)
            timed_out <= 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        ld_params_wr = 1'b0;
        ld_params_rd = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && eng_ok)
                    state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                busy         = 1'b1;
                ld_params_wr = !ld_dir;
                ld_params_rd = ld_dir;
                state_nxt    = ST_HOLD;
            end
            ST_HOLD: begin
                busy = 1'b1;
                if (phase_cnt == '0)
                    state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                // A valid command in the same cycle as go wins; go is dropped.
                if (accept && eng_ok)
                    state_nxt = ST_LOAD;
                else if (launch)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort || all_done)
                    state_nxt = ST_FINISH;
`ifdef LT_SCHED_TIMEOUT_EN
                else if (to_hit)
                    state_nxt = ST_FINISH;
`endif
            end
            ST_FINISH: begin
                done = (phase_cnt == '0);
                if (phase_cnt == '0)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt  <= '0;
            ld_dir     <= 1'b0;
            ld_eng     <= '0;
            lt_params  <= '0;
            arm_wr     <= '0;
            arm_rd     <= '0;
            start_wr   <= '0;
            start_rd   <= '0;
            run_cycles <= '0;
            aborted    <= 1'b0;
        end else begin
            start_wr <= '0;
            start_rd <= '0;

            if ((state_nxt == ST_HOLD) && (state != ST_HOLD))
                phase_cnt <= PHASE_W'(HOLD_LEN - 1);
            else if ((state_nxt == ST_FINISH) && (state != ST_FINISH))
                phase_cnt <= PHASE_W'(FINISH_LEN - 1);
            else if (phase_cnt != '0)
                phase_cnt <= phase_cnt - 1'b1;

            if (accept && eng_ok) begin
                ld_dir <= cmd_dir;
                ld_eng <= cmd_engine;
                if (cmd_dir)
                    lt_params[2*PARAMS_BITS-1:PARAMS_BITS] <= ld_word;
                else
                    lt_params[PARAMS_BITS-1:0] <= ld_word;
            end

            if (state == ST_LOAD) begin
                if (ld_dir)
                    arm_rd <= arm_rd | eng_bit;
                else
                    arm_wr <= arm_wr | eng_bit;
            end

            if (launch) begin
                start_wr   <= arm_wr;
                start_rd   <= arm_rd;
                run_cycles <= '0;
                aborted    <= 1'b0;
            end

            if (state == ST_RUN) begin
                run_cycles <= run_cycles_inc;
                if (abort)
                    aborted <= 1'b1;
            end

            if ((state == ST_FINISH) && (state_nxt == ST_IDLE)) begin
                arm_wr <= '0;
                arm_rd <= '0;
            end
        end
    end

    lt_sched_done_track #(
        .NUM_ENGINES(NUM_ENGINES)
    ) u_done_track (
        .clk     (clk),
        .rst     (rst),
        .clear   (launch),
        .en      (state == ST_RUN),
        .end_wr  (end_wr),
        .end_rd  (end_rd),
        .arm_wr  (arm_wr),
        .arm_rd  (arm_rd),
        .all_done(all_done)
    );

endmodule

// File: tb/tb_lt_sched.sv
// Directed self-checking bench for lt_sched; 8 engines so out-of-range IDs fit the 5-bit field.
module tb_lt_sched;

    localparam int NE = 8;
    localparam int PB = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [4:0]      cmd_engine;
    logic            cmd_dir;
    logic [PB-1:0]   cmd_params;
    logic            go;
    logic            abort;
    logic            ld_params_wr;
    logic            ld_params_rd;
    logic [2*PB-1:0] lt_params;
    logic [NE-1:0]   start_wr;
    logic [NE-1:0]   start_rd;
    logic [NE-1:0]   end_wr;
    logic [NE-1:0]   end_rd;
    logic            busy;
    logic            done;
    logic            aborted;
    logic            timed_out;
    logic [63:0]     run_cycles;

    int tests = 0;
    int fails = 0;

    lt_sched #(
        .NUM_ENGINES   (NE),
        .PARAMS_BITS   (PB),
        .TIMEOUT_CYCLES(64'd100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_engine  (cmd_engine),
        .cmd_dir     (cmd_dir),
        .cmd_params  (cmd_params),
        .go          (go),
        .abort       (abort),
        .ld_params_wr(ld_params_wr),
        .ld_params_rd(ld_params_rd),
        .lt_params   (lt_params),
        .start_wr    (start_wr),
        .start_rd    (start_rd),
        .end_wr      (end_wr),
        .end_rd      (end_rd),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .timed_out   (timed_out),
        .run_cycles  (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command from IDLE/ARMED and returns in ARMED.
    task automatic load(input logic [4:0] eng, input logic dir, input logic [PB-1:0] p);
        cmd_valid  = 1'b1;
        cmd_engine = eng;
        cmd_dir    = dir;
        cmd_params = p;
        step();
        cmd_valid = 1'b0;
        chk("ld_pulse", dir ? ld_params_rd : ld_params_wr, 1'b1);
        chk("ld_id", dir ? lt_params[485:481] : lt_params[229:225], eng);
        step();
        step();
        step();
    endtask

    // Returns at the first RUN cycle, where start pulses are visible.
    task automatic launch_run();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [PB-1:0] p;
        logic [PB-1:0] exp_lo;
        int            done_cnt;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_engine = '0;
        cmd_dir    = 1'b0;
        cmd_params = '0;
        go         = 1'b0;
        abort      = 1'b0;
        end_wr     = '0;
        end_rd     = '0;
        step();
        step();

        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_lt_params", lt_params, '0);
        chk("rst_run_cycles", run_cycles, 64'd0);
        chk("rst_start", {start_wr, start_rd}, 16'h0);

        rst = 1'b0;
        step();
        chk("idle_ready", cmd_ready, 1'b1);

        // Engine 3 write load: 1-cycle ld pulse, ID stamped, ready low 3 cycles
        p      = {32{8'hA5}};
        exp_lo = p;
        exp_lo[229:225] = 5'd3;
        cmd_valid  = 1'b1;
        cmd_engine = 5'd3;
        cmd_dir    = 1'b0;
        cmd_params = p;
        step();
        cmd_valid = 1'b0;
        chk("load_ld_wr", ld_params_wr, 1'b1);
        chk("load_ld_rd", ld_params_rd, 1'b0);
        chk("load_busy", busy, 1'b1);
        chk("load_ready", cmd_ready, 1'b0);
        chk("load_lo", lt_params[255:0], exp_lo);
        chk("load_hi", lt_params[511:256], '0);
        chk("load_id", lt_params[229:225], 5'd3);
        step();
        chk("hold1_ld_wr", ld_params_wr, 1'b0);
        chk("hold1_ready", cmd_ready, 1'b0);
        step();
        chk("hold2_ready", cmd_ready, 1'b0);
        chk("hold2_lo", lt_params[255:0], exp_lo);
        step();
        chk("armed_ready", cmd_ready, 1'b1);
        chk("armed_busy", busy, 1'b0);

        // Short run on engine 3 finishing on its first RUN cycle
        launch_run();
        chk("r3_start_wr", start_wr, 8'h08);
        chk("r3_start_rd", start_rd, 8'h00);
        chk("r3_busy", busy, 1'b1);
        end_wr = 8'h08;
        step();
        end_wr = '0;
        chk("r3_done", done, 1'b1);
        chk("r3_cycles", run_cycles, 64'd1);
        chk("r3_start_off", start_wr, 8'h00);
        step();
        chk("r3_done_off", done, 1'b0);
        chk("r3_idle_ready", cmd_ready, 1'b1);

        // go in IDLE with nothing armed is ignored
        launch_run();
        chk("idle_go_start", {start_wr, start_rd}, 16'h0);
        chk("idle_go_busy", busy, 1'b0);
        chk("idle_go_ready", cmd_ready, 1'b1);

        // Out-of-range engine (40 does not fit 5 bits; 30 >= 8 engines)
        cmd_valid  = 1'b1;
        cmd_engine = 5'd30;
        cmd_dir    = 1'b1;
        cmd_params = '1;
        step();
        cmd_valid = 1'b0;
        chk("bad_eng_ld_wr", ld_params_wr, 1'b0);
        chk("bad_eng_ld_rd", ld_params_rd, 1'b0);
        chk("bad_eng_busy", busy, 1'b0);
        chk("bad_eng_ready", cmd_ready, 1'b1);
        launch_run();
        chk("bad_eng_no_arm", {start_wr, start_rd}, 16'h0);
        chk("bad_eng_idle", busy, 1'b0);

        // Engine 0 wr + engine 5 rd; ends at RUN cycles 10 and 40
        load(5'd0, 1'b0, {8{32'h1357_9BDF}});
        load(5'd5, 1'b1, {8{32'h2468_ACE0}});
        chk("r30_hi_id", lt_params[485:481], 5'd5);
        chk("r30_lo_id", lt_params[229:225], 5'd0);
        launch_run();
        chk("r30_start_wr", start_wr, 8'h01);
        chk("r30_start_rd", start_rd, 8'h20);
        done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            end_wr = (c == 10) ? 8'h01 : ((c == 5) ? 8'h20 : 8'h00);
            end_rd = (c == 40) ? 8'h20 : ((c == 20) ? 8'h01 : 8'h00);
            if (done) done_cnt++;
            step();
        end
        end_wr = '0;
        end_rd = '0;
        chk("r30_no_early_done", done_cnt, 0);
        chk("r30_done", done, 1'b1);
        chk("r30_cycles", run_cycles, 64'd40);
        step();
        chk("r30_done_off", done, 1'b0);
        chk("r30_cycles_hold", run_cycles, 64'd40);
        chk("r30_idle", cmd_ready, 1'b1);

        // Abort together with the final end
        load(5'd2, 1'b0, p);
        launch_run();
        chk("ab_clear", aborted, 1'b0);
        step();
        step();
        abort  = 1'b1;
        end_wr = 8'h04;
        step();
        abort  = 1'b0;
        end_wr = '0;
        chk("ab_done", done, 1'b1);
        chk("ab_aborted", aborted, 1'b1);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) done_cnt++;
        end
        chk("ab_single_done", done_cnt, 0);
        chk("ab_sticky", aborted, 1'b1);
        chk("ab_idle", cmd_ready, 1'b1);

        // Watchdog at 100 RUN cycles with no end
        load(5'd1, 1'b0, p);
        launch_run();
        chk("to_ab_clear", aborted, 1'b0);
        for (int c = 1; c <= 99; c++) step();
        chk("to_99_busy", busy, 1'b1);
        chk("to_99_done", done, 1'b0);
        step();
`ifdef LT_SCHED_TIMEOUT_EN
        chk("to_done", done, 1'b1);
        chk("to_flag", timed_out, 1'b1);
        chk("to_cycles", run_cycles, 64'd100);
        step();
        chk("to_done_off", done, 1'b0);
        chk("to_flag_hold", timed_out, 1'b1);
`else
        chk("nto_busy", busy, 1'b1);
        chk("nto_done", done, 1'b0);
        chk("nto_flag", timed_out, 1'b0);
        chk("nto_cycles", run_cycles, 64'd100);
        step();
        step();
        step();
        chk("nto_cycles_103", run_cycles, 64'd103);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("nto_abort_done", done, 1'b1);
        step();
`endif

        // Reset in the middle of a run
        load(5'd4, 1'b1, p);
        launch_run();
        chk("mr_start_rd", start_rd, 8'h10);
        step();
        step();
        chk("mr_busy", busy, 1'b1);
        chk("mr_cycles", run_cycles, 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_rst_busy", busy, 1'b0);
        chk("mr_rst_done", done, 1'b0);
        chk("mr_rst_ready", cmd_ready, 1'b0);
        chk("mr_rst_cycles", run_cycles, 64'd0);
        chk("mr_rst_params", lt_params, '0);
        chk("mr_rst_flags", {aborted, timed_out, ld_params_wr, ld_params_rd}, 4'h0);
        step();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) done_cnt++;
        end
        chk("mr_no_done", done_cnt, 0);
        chk("mr_idle", cmd_ready, 1'b1);
        chk("mr_idle_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
